// File: rtl/pixel_line_buffer.sv
// Ping-pong line buffer between a pixel stream and a zero-latency display read port.
// Optional underflow line counter is enabled by defining PIXEL_LINE_BUFFER_UFLOW_CNT_EN.
module pixel_line_buffer #(
  parameter int          LINE_W     = 750,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic        pixel_request,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic [23:0] pixel_data,
  output logic        underflow,
  input  logic        clr_underflow,
`ifdef PIXEL_LINE_BUFFER_UFLOW_CNT_EN
  output logic [1:0]  lines_full,
  output logic [15:0] underflow_cnt
`else
  output logic [1:0]  lines_full
`endif
);

  localparam int          AW     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [10:0] LAST_X = 11'(LINE_W - 1);

  typedef enum logic {
    W_SYNC,
    W_FILL
  } wr_state_t;

  wr_state_t   state_q, state_d;
  logic        wr_sel_q, wr_sel_d;
  logic        rd_sel_q, rd_sel_d;
  logic [10:0] wr_x_q, wr_x_d;
  logic [1:0]  lines_full_q, lines_full_d;
  logic        underflow_q, underflow_d;

  logic [23:0] line0_mem [LINE_W];
  logic [23:0] line1_mem [LINE_W];

  logic          accept;
  logic          in_range;
  logic          rd_full;
  logic          rd_hit;
  logic          rd_miss;
  logic          resync;
  logic          store;
  logic [10:0]   wr_x_cur;
  logic          wr_en;
  logic          wr_buf;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_word;
  logic          pixel_y_unused;

  assign pixel_y_unused = ^pixel_y;

  assign s_ready  = rst_n && ((state_q == W_SYNC) || !lines_full_q[wr_sel_q]);
  assign accept   = s_valid && s_ready;
  assign in_range = pixel_request && ({1'b0, pixel_x} < 12'(LINE_W));
  assign rd_full  = lines_full_q[rd_sel_q];
  assign rd_hit   = in_range && rd_full;
  assign rd_miss  = in_range && !rd_full;

  // In W_SYNC the only beat that is stored is the frame start, always at x=0.
  assign wr_x_cur = (state_q == W_SYNC) ? 11'd0 : wr_x_q;
  assign resync   = (state_q == W_FILL) && s_sof && (wr_x_q != 11'd0);
  assign store    = accept && ((state_q == W_FILL) || s_sof);

  assign rd_addr    = pixel_x[AW-1:0];
  assign rd_word    = rd_sel_q ? line1_mem[rd_addr] : line0_mem[rd_addr];
  assign pixel_data = (rst_n && rd_hit) ? rd_word : FILL_COLOR;

  assign lines_full = lines_full_q;
  assign underflow  = underflow_q;

  always_comb begin
    state_d      = state_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    wr_x_d       = wr_x_q;
    lines_full_d = lines_full_q;
    underflow_d  = underflow_q;
    wr_en        = 1'b0;
    wr_buf       = wr_sel_q;
    wr_addr      = wr_x_cur[AW-1:0];

    if (rd_hit && (pixel_x == LAST_X)) begin
      lines_full_d[rd_sel_q] = 1'b0;
      rd_sel_d               = ~rd_sel_q;
    end

    if (clr_underflow) begin
      underflow_d = 1'b0;
    end else if (rd_miss) begin
      underflow_d = 1'b1;
    end

    // A resync overrides whatever the reader did on this edge.
    if (store) begin
      state_d = W_FILL;
      wr_en   = 1'b1;
      if (resync) begin
        lines_full_d = 2'b00;
        wr_sel_d     = 1'b0;
        rd_sel_d     = 1'b0;
        wr_buf       = 1'b0;
        wr_addr      = '0;
        wr_x_d       = 11'd1;
      end else if (wr_x_cur == LAST_X) begin
        lines_full_d[wr_sel_q] = 1'b1;
        wr_sel_d               = ~wr_sel_q;
        wr_x_d                 = 11'd0;
      end else begin
        wr_x_d = wr_x_cur + 11'd1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q      <= W_SYNC;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_x_q       <= 11'd0;
      lines_full_q <= 2'b00;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      wr_x_q       <= wr_x_d;
      lines_full_q <= lines_full_d;
      underflow_q  <= underflow_d;
    end
  end

  // Line storage is never reset; a line is only readable once its full flag is set.
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      if (wr_buf) begin
        line1_mem[wr_addr] <= s_data;
      end else begin
        line0_mem[wr_addr] <= s_data;
      end
    end
  end

`ifdef PIXEL_LINE_BUFFER_UFLOW_CNT_EN
  logic [15:0] uflow_cnt_q, uflow_cnt_d;

  always_comb begin
    uflow_cnt_d = uflow_cnt_q;
    if (clr_underflow) begin
      uflow_cnt_d = 16'd0;
    end else if (rd_miss && (pixel_x == LAST_X) && (uflow_cnt_q != 16'hFFFF)) begin
      uflow_cnt_d = uflow_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      uflow_cnt_q <= 16'd0;
    end else begin
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign underflow_cnt = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_line_buffer.sv
// Self-checking bench for pixel_line_buffer (LINE_W=4): vector table, hand-written
// corner sequences, then random traffic against a queue-of-lines reference model.
module tb_pixel_line_buffer;

  localparam int          TB_W  = 4;
  localparam int          TB_AW = 2;
  localparam logic [23:0] FILL  = 24'h5A5A5A;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_sof;
  logic        s_ready;
  logic        pixel_request;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [23:0] pixel_data;
  logic        underflow;
  logic        clr_underflow;
  logic [1:0]  lines_full;
`ifdef PIXEL_LINE_BUFFER_UFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 pclk = ~pclk;

  pixel_line_buffer #(
    .LINE_W     (TB_W),
    .FILL_COLOR (FILL)
  ) dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sof         (s_sof),
    .s_ready       (s_ready),
    .pixel_request (pixel_request),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_data    (pixel_data),
    .underflow     (underflow),
    .clr_underflow (clr_underflow),
`ifdef PIXEL_LINE_BUFFER_UFLOW_CNT_EN
    .lines_full    (lines_full),
    .underflow_cnt (underflow_cnt)
`else
    .lines_full    (lines_full)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic        vld;
    logic        sof;
    logic [23:0] dat;
    logic        req;
    logic [10:0] px;
    logic        clr;
    logic        e_rdy;
    logic [23:0] e_dat;
    logic [1:0]  e_lf;
    logic        e_uf;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic vld, input logic sof,
                              input logic [23:0] dat, input logic req, input int px,
                              input logic clr, input logic e_rdy, input logic [23:0] e_dat,
                              input logic [1:0] e_lf, input logic e_uf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sof = sof; v.dat = dat; v.req = req;
    v.px = 11'(px); v.clr = clr;
    v.e_rdy = e_rdy; v.e_dat = e_dat; v.e_lf = e_lf; v.e_uf = e_uf;
    return v;
  endfunction

  // Reference model: completed lines wait in a FIFO of at most two; the reader
  // consumes the oldest one. rd_ptr only tracks which physical buffer is oldest.
  typedef logic [TB_W-1:0][23:0] line_t;
  line_t line_q[$];
  line_t part;
  int    wx      = 0;
  bit    syncing = 1'b1;
  bit    rd_ptr  = 1'b0;
  bit    m_uf    = 1'b0;
  bit    m_acc;
  bit    m_uf_set;

  function automatic bit model_ready();
    return rst_n && (syncing || line_q.size() < 2);
  endfunction

  function automatic logic [1:0] model_lf();
    if (line_q.size() == 0) return 2'b00;
    if (line_q.size() == 1) return rd_ptr ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [23:0] model_data();
    if (!rst_n || !pixel_request || pixel_x >= TB_W || line_q.size() == 0) return FILL;
    return line_q[0][pixel_x[TB_AW-1:0]];
  endfunction

  task automatic model_put(input logic [23:0] d);
    part[wx[TB_AW-1:0]] = d;
    wx = wx + 1;
    if (wx == TB_W) begin
      line_q.push_back(part);
      wx = 0;
    end
  endtask

  always @(posedge pclk) begin
    if (!rst_n) begin
      line_q.delete();
      syncing = 1'b1;
      wx      = 0;
      rd_ptr  = 1'b0;
      m_uf    = 1'b0;
    end else begin
      m_acc    = s_valid && model_ready();
      m_uf_set = 1'b0;
      if (pixel_request && pixel_x < TB_W) begin
        if (line_q.size() > 0) begin
          if (pixel_x == TB_W - 1) begin
            void'(line_q.pop_front());
            rd_ptr = !rd_ptr;
          end
        end else begin
          m_uf_set = 1'b1;
        end
      end
      m_uf = clr_underflow ? 1'b0 : (m_uf | m_uf_set);
      if (m_acc) begin
        if (syncing) begin
          if (s_sof) begin
            syncing = 1'b0;
            model_put(s_data);
          end
        end else if (s_sof && wx != 0) begin
          line_q.delete();
          rd_ptr = 1'b0;
          wx     = 0;
          model_put(s_data);
        end else begin
          model_put(s_data);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic e_rdy, input logic [23:0] e_dat,
                             input logic [1:0] e_lf, input logic e_uf);
    n_checks += 4;
    if (s_ready === e_rdy) n_pass++;
    else $display("[TB] FAIL %s s_ready: got %0b want %0b", tag, s_ready, e_rdy);
    if (pixel_data === e_dat) n_pass++;
    else $display("[TB] FAIL %s pixel_data: got %06h want %06h", tag, pixel_data, e_dat);
    if (lines_full === e_lf) n_pass++;
    else $display("[TB] FAIL %s lines_full: got %02b want %02b", tag, lines_full, e_lf);
    if (underflow === e_uf) n_pass++;
    else $display("[TB] FAIL %s underflow: got %0b want %0b", tag, underflow, e_uf);
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later, before the rising edge.
  task automatic applyStimulus(input vec_t v, input bit use_model, input string tag);
    @(negedge pclk);
    rst_n         = v.rst;
    s_valid       = v.vld;
    s_sof         = v.sof;
    s_data        = v.dat;
    pixel_request = v.req;
    pixel_x       = v.px;
    pixel_y       = 11'($urandom_range(0, 1079));
    clr_underflow = v.clr;
    #1;
    if (use_model) checkOutput(tag, model_ready(), model_data(), model_lf(), m_uf);
    else           checkOutput(tag, v.e_rdy, v.e_dat, v.e_lf, v.e_uf);
  endtask

  vec_t tbl [18];

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    pixel_request = 1'b0; pixel_x = '0; pixel_y = '0; clr_underflow = 1'b0;
    repeat (2) @(posedge pclk);

    // Basic line fill/read, underflow set/clear, out-of-range request, clear priority.
    tbl[0]  = mk(0,0,0,0,        0,0,0, 0,FILL,    2'b00,0);
    tbl[1]  = mk(1,1,1,24'd1,    0,0,0, 1,FILL,    2'b00,0);
    tbl[2]  = mk(1,1,0,24'd2,    0,0,0, 1,FILL,    2'b00,0);
    tbl[3]  = mk(1,1,0,24'd3,    0,0,0, 1,FILL,    2'b00,0);
    tbl[4]  = mk(1,1,0,24'd4,    0,0,0, 1,FILL,    2'b00,0);
    tbl[5]  = mk(1,0,0,0,        1,0,0, 1,24'd1,   2'b01,0);
    tbl[6]  = mk(1,0,0,0,        1,1,0, 1,24'd2,   2'b01,0);
    tbl[7]  = mk(1,0,0,0,        1,2,0, 1,24'd3,   2'b01,0);
    tbl[8]  = mk(1,0,0,0,        1,3,0, 1,24'd4,   2'b01,0);
    tbl[9]  = mk(1,0,0,0,        0,0,0, 1,FILL,    2'b00,0);
    tbl[10] = mk(1,0,0,0,        1,0,0, 1,FILL,    2'b00,0);
    tbl[11] = mk(1,0,0,0,        0,0,0, 1,FILL,    2'b00,1);
    tbl[12] = mk(1,0,0,0,        0,0,1, 1,FILL,    2'b00,1);
    tbl[13] = mk(1,0,0,0,        0,0,0, 1,FILL,    2'b00,0);
    tbl[14] = mk(1,0,0,0,        1,5,0, 1,FILL,    2'b00,0);
    tbl[15] = mk(1,0,0,0,        0,0,0, 1,FILL,    2'b00,0);
    tbl[16] = mk(1,0,0,0,        1,1,1, 1,FILL,    2'b00,0);
    tbl[17] = mk(1,0,0,0,        0,0,0, 1,FILL,    2'b00,0);
    for (int i = 0; i < 18; i++) applyStimulus(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Discard before sof, fill both buffers, stall, one-cycle bubble, third line in buffer 0.
    applyStimulus(mk(0,0,0,0,       0,0,0, 0,FILL,2'b00,0), 1'b0, "A_rst");
    applyStimulus(mk(1,1,0,24'h11,  0,0,0, 1,FILL,2'b00,0), 1'b0, "A_disc0");
    applyStimulus(mk(1,1,0,24'h22,  0,0,0, 1,FILL,2'b00,0), 1'b0, "A_disc1");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,1,(i==0),24'h10+24'(i), 0,0,0, 1,FILL,2'b00,0), 1'b0, "A_line0");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,1,0,24'h20+24'(i), 0,0,0, 1,FILL,2'b01,0), 1'b0, "A_line1");
    applyStimulus(mk(1,1,0,24'h30,  0,0,0, 0,FILL,2'b11,0), 1'b0, "A_stall");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,1,0,24'h30, 1,i,0, 0,24'h10+24'(i),2'b11,0), 1'b0, "A_rd0");
    applyStimulus(mk(1,1,0,24'h30,  0,0,0, 1,FILL,2'b10,0), 1'b0, "A_bubble");
    for (int i = 1; i < 4; i++)
      applyStimulus(mk(1,1,0,24'h30+24'(i), 0,0,0, 1,FILL,2'b10,0), 1'b0, "A_line2");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,0,0,0, 1,i,0, 0,24'h20+24'(i),2'b11,0), 1'b0, "A_rd1");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,0,0,0, 1,i,0, 1,24'h30+24'(i),2'b01,0), 1'b0, "A_rd2");
    applyStimulus(mk(1,0,0,0,       0,0,0, 1,FILL,2'b00,0), 1'b0, "A_empty");

    // Short line followed by sof: resync clears both flags and restarts in buffer 0.
    applyStimulus(mk(0,0,0,0,       0,0,0, 0,FILL,2'b00,0), 1'b0, "B_rst");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,1,(i==0),24'(i+1), 0,0,0, 1,FILL,2'b00,0), 1'b0, "B_line0");
    applyStimulus(mk(1,1,0,24'd5,   0,0,0, 1,FILL,2'b01,0), 1'b0, "B_short0");
    applyStimulus(mk(1,1,0,24'd6,   0,0,0, 1,FILL,2'b01,0), 1'b0, "B_short1");
    applyStimulus(mk(1,1,1,24'hABCDEF, 0,0,0, 1,FILL,2'b01,0), 1'b0, "B_sof");
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1,1,0,24'd7+24'(i), 0,0,0, 1,FILL,2'b00,0), 1'b0, "B_fill");
    applyStimulus(mk(1,0,0,0,       1,0,0, 1,24'hABCDEF,2'b01,0), 1'b0, "B_rdx0");
    for (int i = 1; i < 4; i++)
      applyStimulus(mk(1,0,0,0, 1,i,0, 1,24'd6+24'(i),2'b01,0), 1'b0, "B_rd");
    applyStimulus(mk(1,0,0,0,       0,0,0, 1,FILL,2'b00,0), 1'b0, "B_empty");

    // Reset mid-line drops the partial line and the underflow flag; later beats need sof.
    applyStimulus(mk(0,0,0,0,       0,0,0, 0,FILL,2'b00,0), 1'b0, "C_rst0");
    applyStimulus(mk(1,0,0,0,       1,0,0, 1,FILL,2'b00,0), 1'b0, "C_uf");
    applyStimulus(mk(1,1,1,24'h41,  0,0,0, 1,FILL,2'b00,1), 1'b0, "C_px0");
    applyStimulus(mk(1,1,0,24'h42,  0,0,0, 1,FILL,2'b00,1), 1'b0, "C_px1");
    applyStimulus(mk(0,1,0,24'h43,  1,0,0, 0,FILL,2'b00,1), 1'b0, "C_rst1");
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1,1,0,24'h44+24'(i), 0,0,0, 1,FILL,2'b00,0), 1'b0, "C_disc");
    applyStimulus(mk(1,0,0,0,       0,0,0, 1,FILL,2'b00,0), 1'b0, "C_idle");

`ifdef PIXEL_LINE_BUFFER_UFLOW_CNT_EN
    applyStimulus(mk(1,0,0,0,       1,3,0, 1,FILL,2'b00,0), 1'b0, "D_uf");
    applyStimulus(mk(1,0,0,0,       0,0,0, 1,FILL,2'b00,1), 1'b0, "D_idle");
    n_checks++;
    if (underflow_cnt === 16'd1) n_pass++;
    else $display("[TB] FAIL D_cnt underflow_cnt: got %0d want 1", underflow_cnt);
    applyStimulus(mk(1,0,0,0,       0,0,1, 1,FILL,2'b00,1), 1'b0, "D_clr");
    applyStimulus(mk(1,0,0,0,       0,0,0, 1,FILL,2'b00,0), 1'b0, "D_after");
    n_checks++;
    if (underflow_cnt === 16'd0) n_pass++;
    else $display("[TB] FAIL D_cnt_clr underflow_cnt: got %0d want 0", underflow_cnt);
`endif

    // Random traffic checked against the line-FIFO model.
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v = '0;
      v.rst = ($urandom_range(0, 199) != 0);
      v.vld = ($urandom_range(0, 9) < 7);
      v.sof = ($urandom_range(0, 15) == 0);
      v.dat = 24'($urandom);
      v.req = ($urandom_range(0, 1) == 1);
      v.px  = 11'($urandom_range(0, 5));
      v.clr = ($urandom_range(0, 19) == 0);
      applyStimulus(v, 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
